// File: rtl/rng_pkg.sv
// Shared types, constants and pure functions for the xorshift random source.
package rng_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SEED_W = 8;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SEED   = 2'd1,
    PH_WARMUP = 2'd2,
    PH_RUN    = 2'd3
  } phase_e;

  localparam logic [SEED_W-1:0] SEED_XOR = 8'hA5;
  localparam logic [SEED_W-1:0] SEED_PAD = 8'h5A;

  localparam int unsigned SHL_A = 13;
  localparam int unsigned SHR_B = 17;
  localparam int unsigned SHL_C = 5;

  // One xorshift32 step; all shifts logical and truncated to 32 bits.
  function automatic logic [WORD_W-1:0] xorshift32_step(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] t;
    t = x ^ (x << SHL_A);
    t = t ^ (t >> SHR_B);
    return t ^ (t << SHL_C);
  endfunction

  // The constant low byte keeps the expanded seed away from the all-zero lock-up state.
  function automatic logic [WORD_W-1:0] seed_expand(input logic [SEED_W-1:0] seed_id);
    return {seed_id, ~seed_id, seed_id ^ SEED_XOR, SEED_PAD};
  endfunction

endpackage

// File: rtl/rng_fifo.sv
// First-word-fall-through output buffer with flush; every output is a flop.
module rng_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic                        valid,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  // Next-state of storage, pointers and the registered head/status view.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    do_pop   = pop & (fill_q != '0);
    do_push  = push & ((fill_q != FILL_W'(FIFO_DEPTH)) | do_pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fill_d = fill_q + FILL_W'(1);
        2'b01:   fill_d = fill_q - FILL_W'(1);
        default: fill_d = fill_q;
      endcase
    end

    empty_d = (fill_d == '0);
    valid_d = ~empty_d;
    full_d  = (fill_d == FILL_W'(FIFO_DEPTH));
    head_d  = empty_d ? '0 : mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: it is only visible through head, which is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign fill  = fill_q;

endmodule

// File: rtl/xorshift_rng.sv
// Seeded xorshift32 source: seed expansion, fixed warm-up, then one step per free FIFO slot.
module xorshift_rng
  import rng_pkg::*;
#(
  parameter int unsigned WARMUP_STEPS = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  seed_ID,
  input  logic                        start,
  output logic [31:0]                 rnd_data,
  output logic                        rnd_valid,
  input  logic                        rnd_ready,
  output logic [1:0]                  phase,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int unsigned CNT_W = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;

  phase_e            phase_q, phase_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [WORD_W-1:0] x_step;
  logic              fifo_push, fifo_flush, fifo_pop;
  logic              fifo_full, fifo_empty;

  assign fifo_pop = rnd_ready & ~fifo_empty;

  // Phase sequencing and generator advance; start overrides whatever the phase wanted.
  always_comb begin
    phase_d    = phase_q;
    x_d        = x_q;
    cnt_d      = cnt_q;
    seed_d     = seed_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    x_step     = xorshift32_step(x_q);

    case (phase_q)
      PH_IDLE: begin
        phase_d = PH_IDLE;
      end
      PH_SEED: begin
        x_d        = seed_expand(seed_q);
        cnt_d      = '0;
        fifo_flush = 1'b1;
        phase_d    = PH_WARMUP;
      end
      PH_WARMUP: begin
        x_d   = x_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WARMUP_STEPS - 1)) begin
          phase_d = PH_RUN;
        end
      end
      PH_RUN: begin
        // Hold x while the buffer is full so no step is ever skipped.
        if (!fifo_full || fifo_pop) begin
          x_d       = x_step;
          fifo_push = 1'b1;
        end
      end
      default: begin
        phase_d = PH_IDLE;
      end
    endcase

    if (start) begin
      seed_d     = seed_ID;
      phase_d    = PH_SEED;
      x_d        = x_q;
      cnt_d      = cnt_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      seed_q  <= '0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
    end
  end

  rng_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (x_step),
    .pop       (fifo_pop),
    .head      (rnd_data),
    .valid     (rnd_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign phase = phase_q;

endmodule

// File: tb/tb_xorshift_rng.sv
// Bench for xorshift_rng: stream model indexed by step count from the expanded seed.
module tb_xorshift_rng;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seed_ID;
  logic        start;
  logic [31:0] rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [1:0]  phase;
  logic [2:0]  fill;

  int n_checks = 0;
  int n_pass   = 0;
  int accepted = 0;

  bit          model_on  = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] exp_x     = '0;

  always #5 clk = ~clk;

  xorshift_rng #(
    .WARMUP_STEPS (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_ID   (seed_ID),
    .start     (start),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .phase     (phase),
    .fill      (fill)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    logic [31:0] a;
    a = x ^ (x << 13);
    a = a ^ (a >> 17);
    return a ^ (a << 5);
  endfunction

  // Word reached after n steps from the expanded seed.
  function automatic logic [31:0] ref_word(input logic [7:0] s, input int n);
    logic [31:0] x;
    x = {s, ~s, s ^ 8'hA5, 8'h5A};
    for (int i = 0; i < n; i++) x = ref_step(x);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle checker: invariants plus the accepted-word stream against the model.
  always @(negedge clk) begin
    check("fill_range", 32'(fill <= 3'd4), 32'd1);
    check("valid_vs_fill", 32'(rnd_valid), 32'(fill != 3'd0));
    if (!rnd_valid) check("empty_data", rnd_data, 32'h0);
    if (prev_hold) begin
      check("hold_valid", 32'(rnd_valid), 32'd1);
      check("hold_data", rnd_data, prev_data);
    end
    if (!model_on) begin
      check("idle_valid", 32'(rnd_valid), 32'd0);
    end else if (rnd_valid && rnd_ready && !reset) begin
      check("stream", rnd_data, exp_x);
      exp_x = ref_step(exp_x);
      accepted++;
    end
    prev_hold = rnd_valid && !rnd_ready && !start && !reset;
    prev_data = rnd_data;
    if (reset) begin
      model_on = 1'b0;
    end else if (start) begin
      model_on = 1'b1;
      exp_x    = ref_word(seed_ID, 9);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    bit         found;

    reset     = 1'b1;
    start     = 1'b0;
    rnd_ready = 1'b0;
    seed_ID   = 8'h00;

    // Hand-computed pins for the model itself.
    s = 8'h00;
    check("pin_seed00", ref_word(s, 0), 32'h00FFA55A);
    s = 8'hFF;
    check("pin_seedFF", ref_word(s, 0), 32'hFF005A5A);
    s = 8'h3C;
    check("pin_seed3C", ref_word(s, 0), 32'h3CC3995A);
    check("pin_step1", ref_step(32'h1), 32'h00042021);

    repeat (2) tick();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_data", rnd_data, 32'h0);
    check("rst_fill", 32'(fill), 32'd0);
    reset = 1'b0;
    tick();

    // Phase sequence and first-word latency with an always-ready consumer.
    rnd_ready = 1'b1;
    seed_ID   = 8'h00;
    accepted  = 0;
    check("t1_phase_c0", 32'(phase), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      check("t1_phase", 32'(phase), (k == 1) ? 32'd1 : (k <= 9) ? 32'd2 : 32'd3);
      check("t1_valid", 32'(rnd_valid), 32'(k >= 11));
      tick();
    end
    check("t1_words", 32'(accepted >= 16), 32'd1);

    // Stalled consumer fills the buffer; then a single pop, then a drain.
    rnd_ready = 1'b0;
    seed_ID   = 8'h3C;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("t2_fill_full", 32'(fill), 32'd4);
    check("t2_phase", 32'(phase), 32'd3);
    check("t2_head", rnd_data, ref_word(8'h3C, 9));
    accepted  = 0;
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    check("t6_fill", 32'(fill), 32'd4);
    check("t6_head", rnd_data, ref_word(8'h3C, 10));
    tick();
    check("t6_head_hold", rnd_data, ref_word(8'h3C, 10));
    rnd_ready = 1'b1;
    repeat (8) tick();
    check("t2_accepted", 32'(accepted), 32'd9);

    // Random back-pressure.
    rnd_ready = 1'b0;
    seed_ID   = 8'h01;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    accepted = 0;
    for (int k = 0; k < 200; k++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t3_progress", 32'(accepted >= 20), 32'd1);

    // Restart from RUN with two words buffered.
    rnd_ready = 1'b0;
    seed_ID   = 8'h01;
    start     = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (phase == 2'd3 && fill == 3'd2) found = 1'b1;
      else tick();
    end
    check("t4_reach_fill2", 32'(found), 32'd1);
    seed_ID = 8'hFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("t4_fill", 32'(fill), 32'd0);
    check("t4_valid", 32'(rnd_valid), 32'd0);
    check("t4_phase", 32'(phase), 32'd1);
    repeat (12) tick();
    check("t4_new_valid", 32'(rnd_valid), 32'd1);
    check("t4_new_head", rnd_data, ref_word(8'hFF, 9));

    // Reset during warm-up beats a simultaneous start.
    rnd_ready = 1'b1;
    seed_ID   = 8'h5A;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t5_in_warmup", 32'(phase), 32'd2);
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("t5_phase", 32'(phase), 32'd0);
    check("t5_valid", 32'(rnd_valid), 32'd0);
    check("t5_data", rnd_data, 32'h0);
    check("t5_fill", 32'(fill), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (20) tick();
    check("t5_stay_idle", 32'(phase), 32'd0);
    check("t5_no_output", 32'(rnd_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
